// File: rtl/icache_app_burst_resp.sv
// Wishbone burst-read / single-beat-write responder over a 1-cycle synchronous SRAM.
// Optional ICACHE_RESP_WAIT_EN adds cfg_wait idle cycles between successive reads.
module icache_app_burst_resp #(
    parameter int WB_AW  = 32,
    parameter int WB_DW  = 32,
    parameter int MEM_AW = 9
) (
    input  logic              mclk,
    input  logic              rst,
`ifdef ICACHE_RESP_WAIT_EN
    input  logic [3:0]        cfg_wait,
`endif
    input  logic              wb_app_stb_i,
    input  logic [WB_AW-1:0]  wb_app_adr_i,
    input  logic              wb_app_we_i,
    input  logic [WB_DW-1:0]  wb_app_dat_i,
    input  logic [3:0]        wb_app_sel_i,
    input  logic [9:0]        wb_app_bl_i,
    output logic [WB_DW-1:0]  wb_app_dat_o,
    output logic              wb_app_ack_o,
    output logic              wb_app_lack_o,
    output logic              mem_csb,
    output logic              mem_web,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [3:0]        mem_wmask,
    output logic [WB_DW-1:0]  mem_din,
    input  logic [WB_DW-1:0]  mem_dout,
    output logic              resp_busy
);

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_LAST, WR, DONE} state_t;

    state_t             state, state_d;
    logic [MEM_AW-1:0]  rd_ptr, rd_ptr_d;
    logic [9:0]         icnt, icnt_d, rcnt, rcnt_d;
    logic [WB_DW-1:0]   wdat, wdat_d;
    logic [3:0]         wsel, wsel_d;
    logic               v1, v2, issue;
    logic               ack_d, lack_d, csb_d, web_d;
    logic [MEM_AW-1:0]  addr_d;
    logic [3:0]         wmask_d;
    logic [WB_DW-1:0]   din_d;
    logic [9:0]         len;
    logic               unused_adr;

`ifdef ICACHE_RESP_WAIT_EN
    logic [3:0]         wcfg, wcfg_d, wcnt, wcnt_d;
`endif

    assign unused_adr = ^{wb_app_adr_i[WB_AW-1:MEM_AW+2], wb_app_adr_i[1:0]};
    assign len = (wb_app_bl_i == 10'd0) ? 10'd1 : wb_app_bl_i;

    always_comb begin
        state_d  = state;
        rd_ptr_d = rd_ptr;
        icnt_d   = icnt;
        rcnt_d   = rcnt;
        wdat_d   = wdat;
        wsel_d   = wsel;
        issue    = 1'b0;
        ack_d    = 1'b0;
        lack_d   = 1'b0;
        csb_d    = 1'b1;
        web_d    = 1'b1;
        addr_d   = mem_addr;
        wmask_d  = mem_wmask;
        din_d    = mem_din;
`ifdef ICACHE_RESP_WAIT_EN
        wcfg_d   = wcfg;
        wcnt_d   = wcnt;
`endif
        // Returning read data: one ack per word, lack on the final word.
        if (v2) begin
            ack_d  = 1'b1;
            lack_d = (rcnt == 10'd1);
            rcnt_d = rcnt - 10'd1;
        end
        unique case (state)
            IDLE: begin
                if (wb_app_stb_i) begin
                    rd_ptr_d = wb_app_adr_i[MEM_AW+1:2];
                    if (wb_app_we_i) begin
                        wdat_d  = wb_app_dat_i;
                        wsel_d  = wb_app_sel_i;
                        state_d = WR;
                    end else begin
                        icnt_d  = len;
                        rcnt_d  = len;
                        state_d = RD_ISSUE;
                    end
                end
`ifdef ICACHE_RESP_WAIT_EN
                wcfg_d = cfg_wait;
                wcnt_d = 4'd0;
`endif
            end
            RD_ISSUE: begin
`ifdef ICACHE_RESP_WAIT_EN
                if (wcnt != 4'd0) begin
                    wcnt_d = wcnt - 4'd1;
                end else begin
                    issue  = 1'b1;
                    wcnt_d = wcfg;
                end
`else
                issue = 1'b1;
`endif
                if (issue) begin
                    csb_d    = 1'b0;
                    addr_d   = rd_ptr;
                    rd_ptr_d = rd_ptr + 1'b1;
                    icnt_d   = icnt - 10'd1;
                    if (icnt == 10'd1) state_d = RD_LAST;
                end
            end
            RD_LAST: begin
                if (wb_app_lack_o) state_d = DONE;
            end
            WR: begin
                csb_d   = 1'b0;
                web_d   = 1'b0;
                addr_d  = rd_ptr;
                wmask_d = wsel;
                din_d   = wdat;
                ack_d   = 1'b1;
                lack_d  = 1'b1;
                state_d = DONE;
            end
            // Initiator still holds stb here; ignore it so the burst is not retriggered.
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            state         <= IDLE;
            rd_ptr        <= '0;
            icnt          <= '0;
            rcnt          <= '0;
            wdat          <= '0;
            wsel          <= '0;
            v1            <= 1'b0;
            v2            <= 1'b0;
            wb_app_dat_o  <= '0;
            wb_app_ack_o  <= 1'b0;
            wb_app_lack_o <= 1'b0;
            mem_csb       <= 1'b1;
            mem_web       <= 1'b1;
            mem_addr      <= '0;
            mem_wmask     <= '0;
            mem_din       <= '0;
            resp_busy     <= 1'b0;
`ifdef ICACHE_RESP_WAIT_EN
            wcfg          <= '0;
            wcnt          <= '0;
`endif
        end else begin
            state         <= state_d;
            rd_ptr        <= rd_ptr_d;
            icnt          <= icnt_d;
            rcnt          <= rcnt_d;
            wdat          <= wdat_d;
            wsel          <= wsel_d;
            v1            <= issue;
            v2            <= v1;
            if (v2) wb_app_dat_o <= mem_dout;
            wb_app_ack_o  <= ack_d;
            wb_app_lack_o <= lack_d;
            mem_csb       <= csb_d;
            mem_web       <= web_d;
            mem_addr      <= addr_d;
            mem_wmask     <= wmask_d;
            mem_din       <= din_d;
            resp_busy     <= (state_d != IDLE);
`ifdef ICACHE_RESP_WAIT_EN
            wcfg          <= wcfg_d;
            wcnt          <= wcnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_icache_app_burst_resp.sv
// Bench for icache_app_burst_resp: SRAM model, transaction-level reference and per-cycle compare.
// Honours ICACHE_RESP_WAIT_EN when the design is built with it.
module tb_icache_app_burst_resp;

    logic        mclk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0;
    logic [31:0] adr = '0;
    logic        we = 1'b0;
    logic [31:0] wdat = '0;
    logic [3:0]  sel = '0;
    logic [9:0]  bl = '0;
    logic [31:0] dat;
    logic        ack, lack, csb, web, busy;
    logic [8:0]  maddr;
    logic [3:0]  wmask;
    logic [31:0] din;
    logic [31:0] dout = '0;
`ifdef ICACHE_RESP_WAIT_EN
    logic [3:0]  cfg_w = '0;
`endif

    icache_app_burst_resp dut (
        .mclk          (mclk),
        .rst           (rst),
`ifdef ICACHE_RESP_WAIT_EN
        .cfg_wait      (cfg_w),
`endif
        .wb_app_stb_i  (stb),
        .wb_app_adr_i  (adr),
        .wb_app_we_i   (we),
        .wb_app_dat_i  (wdat),
        .wb_app_sel_i  (sel),
        .wb_app_bl_i   (bl),
        .wb_app_dat_o  (dat),
        .wb_app_ack_o  (ack),
        .wb_app_lack_o (lack),
        .mem_csb       (csb),
        .mem_web       (web),
        .mem_addr      (maddr),
        .mem_wmask     (wmask),
        .mem_din       (din),
        .mem_dout      (dout),
        .resp_busy     (busy)
    );

    always #5 mclk = ~mclk;

    int cyc = 0;
    always @(posedge mclk) cyc <= cyc + 1;

    // Backing SRAM: 1-cycle read latency, byte-masked writes.
    logic [31:0] sram [512];
    bit preloaded = 1'b0;
    always @(posedge mclk) begin
        if (!preloaded) begin
            for (int k = 0; k < 512; k++) sram[k] <= 32'hA500_0000 + k;
            preloaded <= 1'b1;
        end else if (!csb) begin
            if (!web) begin
                for (int b = 0; b < 4; b++)
                    if (wmask[b]) sram[maddr][8*b +: 8] <= din[8*b +: 8];
            end else begin
                dout <= sram[maddr];
            end
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Reference: expected memory contents and the current transaction.
    logic [31:0] ref_mem [512];
    int t_kind = 0;
    int t_n = 0, t_len = 0, t_base = 0, t_wait = 0;
    int t_abort = 1 << 30;
    int wait_v = 0;
    bit chk_en = 1'b0;

    int d, kk, last;
    logic e_ack, e_lack, e_busy;
    always @(negedge mclk) begin
        if (chk_en) begin
            e_ack = 1'b0; e_lack = 1'b0; e_busy = 1'b0; kk = -1;
            if (cyc < t_abort && t_kind == 1) begin
                d = cyc - t_n - 3;
                last = t_n + 3 + (t_len - 1) * (t_wait + 1);
                if (d >= 0) begin
                    if (d % (t_wait + 1) == 0 && d / (t_wait + 1) < t_len) begin
                        kk = d / (t_wait + 1);
                        e_ack = 1'b1;
                        e_lack = (kk == t_len - 1);
                    end
                end
                e_busy = (cyc >= t_n) && (cyc <= last + 1);
            end else if (cyc < t_abort && t_kind == 2) begin
                e_ack = (cyc == t_n + 1);
                e_lack = e_ack;
                e_busy = (cyc >= t_n) && (cyc <= t_n + 1);
            end
            chk("ack", {31'd0, ack}, {31'd0, e_ack});
            chk("lack", {31'd0, lack}, {31'd0, e_lack});
            chk("busy", {31'd0, busy}, {31'd0, e_busy});
            if (kk >= 0) chk("rdata", dat, ref_mem[(t_base + kk) % 512]);
            if (!e_busy) chk("csb_idle", {31'd0, csb}, 32'd1);
        end
    end

    logic [31:0] got [$];
    int ack_cyc [$];
    int lack_cyc, first_ack;
    logic busy_after [3];

    task automatic do_read(input logic [31:0] a, input logic [9:0] b,
                           input int abort_at, input bit drop_early);
        bit done = 1'b0;
        int seen = 0;
        @(negedge mclk);
        stb = 1'b1; we = 1'b0; adr = a; bl = b;
        t_n = cyc + 1; t_len = (b == 10'd0) ? 1 : int'(b);
        t_base = int'(a[10:2]); t_wait = wait_v; t_abort = 1 << 30; t_kind = 1;
        got.delete(); ack_cyc.delete(); first_ack = -1; lack_cyc = -1;
        for (int i = 0; i < 20000 && !done; i++) begin
            @(negedge mclk);
            if (ack) begin
                got.push_back(dat); ack_cyc.push_back(cyc); seen++;
                if (first_ack < 0) first_ack = cyc;
                if (drop_early) stb = 1'b0;
                if (abort_at != 0 && seen == abort_at) begin
                    rst = 1'b1; stb = 1'b0; t_abort = cyc + 1; done = 1'b1;
                end
            end
            if (lack && !done) begin
                lack_cyc = cyc; stb = 1'b0; done = 1'b1;
            end
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL read_timeout: no lack for adr %h bl %0d", a, b);
            stb = 1'b0;
        end
        if (abort_at != 0) begin
            @(negedge mclk);
            chk("rst_ack", {31'd0, ack}, 32'd0);
            chk("rst_csb", {31'd0, csb}, 32'd1);
            rst = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge mclk);
            busy_after[i] = busy;
        end
        t_kind = 0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] v);
        bit done = 1'b0;
        int w = int'(a[10:2]);
        @(negedge mclk);
        stb = 1'b1; we = 1'b1; adr = a; sel = s; wdat = v;
        t_n = cyc + 1; t_abort = 1 << 30; t_kind = 2;
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[w][8*b +: 8] = v[8*b +: 8];
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge mclk);
            if (lack) done = 1'b1;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL write_timeout: no lack for adr %h", a);
        end
        stb = 1'b0; we = 1'b0;
        repeat (3) @(negedge mclk);
        t_kind = 0;
    endtask

    initial begin
        for (int k = 0; k < 512; k++) ref_mem[k] = 32'hA500_0000 + k;
        repeat (3) @(posedge mclk);
        @(negedge mclk);
        chk("rst_dat", dat, 32'd0);
        chk("rst_ack", {30'd0, ack, lack}, 32'd0);
        chk("rst_csb_web", {30'd0, csb, web}, 32'd3);
        chk("rst_addr", {23'd0, maddr}, 32'd0);
        chk("rst_wmask", {28'd0, wmask}, 32'd0);
        chk("rst_din", din, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        do_read(32'h80, 10'd32, 0, 1'b0);
        chk("b32_count", got.size(), 32);
        chk("b32_latency", first_ack - t_n, 3);
        chk("b32_first", got[0], 32'hA500_0020);
        chk("b32_last", got[31], 32'hA500_003F);

        do_read(32'h0, 10'h200, 0, 1'b0);
        chk("pf_count", got.size(), 512);
        chk("pf_last", got[511], 32'hA500_01FF);
        chk("pf_busy1", {31'd0, busy_after[0]}, 32'd1);
        chk("pf_busy2", {31'd0, busy_after[1]}, 32'd0);

        do_read(32'h7F8, 10'd4, 0, 1'b0);
        chk("wrap0", got[0], 32'hA500_01FE);
        chk("wrap1", got[1], 32'hA500_01FF);
        chk("wrap2", got[2], 32'hA500_0000);
        chk("wrap3", got[3], 32'hA500_0001);

        do_write(32'h10, 4'b1111, 32'hFFFF_FFFF);
        do_write(32'h10, 4'b0101, 32'h1122_3344);
        do_read(32'h10, 10'd1, 0, 1'b0);
        chk("wr_data", got[0], 32'hFF22_FF44);
        chk("wr_ack_lack", first_ack, lack_cyc);

        do_read(32'h0, 10'd0, 0, 1'b0);
        chk("bl0_count", got.size(), 1);

        do_read(32'h100, 10'd32, 10, 1'b0);
        chk("abort_count", got.size(), 10);
        do_read(32'h40, 10'd2, 0, 1'b0);
        chk("post_rst0", got[0], 32'hA500_0010);
        chk("post_rst1", got[1], 32'hA500_0011);

        do_read(32'hFFFF_F000, 10'd3, 0, 1'b1);
        chk("hi_adr_drop", got.size(), 3);

`ifdef ICACHE_RESP_WAIT_EN
        cfg_w = 4'd2; wait_v = 2;
        do_read(32'h200, 10'd4, 0, 1'b0);
        for (int i = 0; i < 3; i++) chk("wait_gap", ack_cyc[i+1] - ack_cyc[i], 3);
        chk("wait_lack", lack_cyc, ack_cyc[3]);
        cfg_w = 4'd0; wait_v = 0;
`endif

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_write($urandom, 4'($urandom_range(0, 15)), $urandom);
            end else if ($urandom_range(0, 5) == 0) begin
                do_read($urandom, 10'($urandom_range(0, 1023)), 0, 1'b0);
            end else begin
                do_read($urandom, 10'($urandom_range(0, 40)), 0,
                        $urandom_range(0, 3) == 0);
            end
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
